// File: rtl/cnt_pkg.sv
// Shared counter definitions: state encoding for countdown_timer and a helper
// that sizes a counter able to hold 0..max.
package cnt_pkg;

  typedef enum logic [1:0] {
    CT_IDLE,
    CT_RUN,
    CT_DONE
  } ct_state_t;

  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a valid/ready load handshake and a one-cycle done pulse.
// Optional feature: define AUTO_RELOAD_EN for periodic auto-reload on expiry.
module countdown_timer
  import cnt_pkg::*;
#(
  parameter  int MAX_COUNT = 255,
  localparam int W         = cnt_width(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [W-1:0] load_value,
  output logic         load_ready,
  input  logic         en,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);

  ct_state_t    state_q, state_d;
  logic [W-1:0] count_d;
  logic         done_d;
  logic         handshake;
  logic [W-1:0] sat_value;

`ifdef AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  // Out-of-range loads clamp silently to MAX_COUNT.
  assign sat_value = (load_value > MAX_W) ? MAX_W : load_value;
  assign handshake = load_valid && load_ready;

  // State, count and done pulse registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CT_IDLE;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      done    <= done_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  // NOTE: the reload register is a single word, not a memory, so resetting it
  // is cheap and keeps its contents defined before the first load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else        reload_q <= reload_d;
  end
`endif

  // Next-state and next-count logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count;
    done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      CT_IDLE, CT_DONE: begin
        if (handshake) begin
          count_d = sat_value;
`ifdef AUTO_RELOAD_EN
          reload_d = sat_value;
`endif
          // A zero load skips RUN and reports completion straight away.
          if (sat_value == '0) begin
            state_d = CT_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CT_RUN;
          end
        end else begin
          state_d = CT_IDLE;
          count_d = '0;
        end
      end
      CT_RUN: begin
        if (abort) begin
          state_d = CT_IDLE;
          count_d = '0;
        end else if (en) begin
          if (count == W'(1)) begin
            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = CT_DONE;
`endif
          end else if (count != '0) begin
            count_d = count - W'(1);
          end
        end
      end
      default: begin
        state_d = CT_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs decoded from state; abort blocks the handshake in the same cycle.
  always_comb begin
    busy       = (state_q == CT_RUN);
    load_ready = (state_q != CT_RUN) && !abort;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random traffic,
// checked cycle by cycle against a tick-counting reference model.
module tb_countdown_timer;

  localparam int MAX = 200;
  localparam int W   = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         load_ready;
  logic         en = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  countdown_timer #(.MAX_COUNT(MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .en         (en),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit bsy;
    bit dn;
    bit rdy;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: remaining en-ticks, whether a countdown is active, the
  // pending done pulse and the period remembered for auto-reload.
  bit m_running = 1'b0;
  int m_left    = 0;
  bit m_pulse   = 1'b0;
  int m_period  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_left    = 0;
    m_pulse   = 1'b0;
    m_period  = 0;
  endtask

  task automatic model_advance(input bit lv, input int val, input bit e, input bit ab);
    int v;
    bit was_idle;
    was_idle = !m_running;
    m_pulse  = 1'b0;
    if (!was_idle) begin
      if (ab) begin
        m_running = 1'b0;
        m_left    = 0;
      end else if (e) begin
        if (m_left == 1) begin
          m_pulse = 1'b1;
`ifdef AUTO_RELOAD_EN
          m_left = m_period;
`else
          m_running = 1'b0;
          m_left    = 0;
`endif
        end else begin
          m_left = m_left - 1;
        end
      end
    end else if (lv && !ab) begin
      v        = (val > MAX) ? MAX : val;
      m_period = v;
      if (v == 0) begin
        m_pulse = 1'b1;
        m_left  = 0;
      end else begin
        m_running = 1'b1;
        m_left    = v;
      end
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue the expected view.
  task automatic step(input bit r, input bit lv, input int val, input bit e, input bit ab);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n      = r;
    load_valid = lv;
    load_value = W'(val);
    en         = e;
    abort      = ab;
    if (!r) model_reset();
    x.cnt = m_left;
    x.bsy = m_running;
    x.dn  = m_pulse;
    x.rdy = !m_running && !ab;
    sb_q.push_back(x);
    if (r) model_advance(lv, val, e, ab);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("count",      32'(count),      32'(e.cnt));
      check("busy",       32'(busy),       32'(e.bsy));
      check("done",       32'(done),       32'(e.dn));
      check("load_ready", 32'(load_ready), 32'(e.rdy));
    end
  end

  initial begin
    // Reset held with a pending load request.
    repeat (3) step(0, 1, 5, 0, 0);
    step(1, 0, 0, 0, 0);

    // Load 5 with en held high.
    step(1, 1, 5, 1, 0);
    repeat (8) step(1, 0, 0, 1, 0);

    // Load 3 with en toggling.
    step(1, 1, 3, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, (i % 2) == 0, 0);

    // Zero load, then a saturating load that is left idling and aborted.
    step(1, 1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 1, 0);
    step(1, 1, 250, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);

    // Load 10, abort once count reaches 4, then abort racing a load.
    step(1, 1, 10, 1, 0);
    repeat (6) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    step(1, 1, 7, 1, 1);
    repeat (2) step(1, 0, 0, 1, 0);

    // Load accepted during the done cycle.
    step(1, 1, 2, 1, 0);
    repeat (2) step(1, 0, 0, 1, 0);
    step(1, 1, 3, 1, 0);
    repeat (5) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);

    // Period-4 run: periodic with auto-reload, single shot otherwise.
    step(1, 1, 4, 1, 0);
    repeat (13) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    repeat (2) step(1, 0, 0, 1, 0);

    // Period-1 run.
    step(1, 1, 1, 1, 0);
    repeat (4) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);

    // Reset pulled mid-count.
    step(1, 1, 20, 1, 0);
    repeat (5) step(1, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 1, 0);

    // Random traffic, including random reset pulses.
    for (int i = 0; i < 600; i++) begin
      bit r, lv, e, ab;
      int val;
      r   = ($urandom_range(0, 39) != 0);
      lv  = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 3) != 0);
      ab  = ($urandom_range(0, 24) == 0);
      val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      step(r, lv, val, e, ab);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
